// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: pipeline-side control/head outputs and the
// instruction-memory request/acknowledge channel.
interface fetch_queue_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        imReq;
   logic [31:0] imAddr;
   logic        imAck;
   logic [31:0] imData;
   logic        instValid;
   logic [31:0] instruction;
   logic [31:0] pcAdd4;

   modport master (
      input  stall, redirect, redirectPc, imAck, imData,
      output imReq, imAddr, instValid, instruction, pcAdd4
   );

   modport slave (
      output stall, redirect, redirectPc, imAck, imData,
      input  imReq, imAddr, instValid, instruction, pcAdd4
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory request, DEPTH-entry FIFO of
// {pc+4, instr}, redirect flushes the queue and discards any in-flight response.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          req_q, req_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   fpc_q, fpc_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   pc4_mem_q [DEPTH];
   logic [31:0]   ins_mem_q [DEPTH];

   logic          head_v, pop, push, room;
   logic [31:0]   addr_inc;

   assign head_v   = (cnt_q != '0);
   assign pop      = head_v && !bus.stall && !bus.redirect;
   assign push     = (state_q == WAIT) && bus.imAck && !bus.redirect;
   assign addr_inc = addr_q + 32'd4;

   always_comb begin
      cnt_d = cnt_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      if (bus.redirect) begin
         cnt_d = '0;
         rd_d  = '0;
         wr_d  = '0;
      end else begin
         cnt_d = cnt_q + CW'(push) - CW'(pop);
         rd_d  = rd_q + PW'(pop);
         wr_d  = wr_q + PW'(push);
      end
   end

   // Issue only if the post-edge occupancy leaves a slot for the response.
   assign room = (cnt_d < FULL);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      fpc_d   = fpc_q;
      case (state_q)
         IDLE: begin
            if (!bus.redirect && room) begin
               state_d = WAIT;
               req_d   = 1'b1;
               addr_d  = fpc_q;
            end
         end
         WAIT: begin
            if (bus.redirect) begin
               if (bus.imAck) begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end else begin
                  state_d = DROP;
               end
            end else if (bus.imAck) begin
               fpc_d = addr_inc;
               if (room) begin
                  addr_d = addr_inc;
               end else begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end
            end
         end
         DROP: begin
            if (bus.imAck) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
      if (bus.redirect) begin
         fpc_d = {bus.redirectPc[31:2], 2'b00};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= {RESET_PC[31:2], 2'b00};
         fpc_q   <= {RESET_PC[31:2], 2'b00};
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         fpc_q   <= fpc_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc4_mem_q[wr_q] <= addr_inc;
         ins_mem_q[wr_q] <= bus.imData;
      end
   end

   assign bus.imReq       = req_q;
   assign bus.imAddr      = addr_q;
   assign bus.instValid   = head_v;
   assign bus.instruction = head_v ? ins_mem_q[rd_q] : '0;
   assign bus.pcAdd4      = head_v ? pc4_mem_q[rd_q] : '0;
endmodule
